load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ex_valid  input  1  memory operation presented by EX/MEM.
- ex_ready  output  1  operation accepted this cycle.
- memread  input  1  load.
- memwrite  input  1  store.
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  `REG_DATA_WIDTH  byte address.
- store_data  input  `REG_DATA_WIDTH  unaligned store source, low bytes significant.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write.
- mem_addr  output  `REG_DATA_WIDTH  word address, bits [1:0] = 0.
- mem_be  output  4  byte enables.
- mem_wdata  output  `REG_DATA_WIDTH  lane-shifted store data.
- mem_rdata  input  `REG_DATA_WIDTH  bus read word.
- mem_ack  input  1  bus completion, single-cycle pulse.
- data_o  output  `REG_DATA_WIDTH  extended load result; feeds WB data_i.
- done  output  1  one-cycle pulse when the operation completes.
- misalign  output  1  one-cycle pulse on a rejected misaligned access.
- stall  output  1  pipeline hold while an operation is outstanding.

Function
REQ-002 The FSM SHALL have exactly three states, with the following transitions:
- IDLE -> REQ on ex_valid & (memread | memwrite) & aligned.
- REQ -> RESP on mem_ack.
- RESP -> IDLE unconditionally.
REQ-003 ex_ready SHALL be 1 only in IDLE; an operation is accepted on the ex_valid & ex_ready edge, and addr, funct3, store_data, memread and memwrite SHALL be registered at that edge.
REQ-004 Alignment rules:
- H/HU with addr[0] = 1 is misaligned.
- W with addr[1:0] != 0 is misaligned.
- A misaligned operation SHALL NOT enter REQ; misalign SHALL pulse on the next cycle and no bus request SHALL be issued.
REQ-005 In REQ, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL stay constant until and including the mem_ack cycle.
REQ-006 mem_be SHALL be:
- B: 4'b0001 << addr[1:0].
- H: 4'b0011 << addr[1:0].
- W: 4'b1111.
- Loads: 4'b1111.
REQ-007 mem_wdata SHALL be store_data replicated into the selected lanes (byte replicated ×4, half ×2).
REQ-008 On mem_ack for a load, mem_rdata SHALL be shifted right by 8*addr[1:0] and then extended per funct3: B/H sign-extend, BU/HU zero-extend, W unchanged. The result SHALL be registered into data_o.
REQ-009 done SHALL be 1 exactly in RESP. data_o SHALL hold its value until the next completed load. Stores SHALL leave data_o unchanged.
REQ-010 stall SHALL be 1 in REQ and SHALL also be 1 in the IDLE accept cycle, so a new operation is never lost.
REQ-011 ex_valid with neither memread nor memwrite SHALL be accepted with no bus activity, no done and no misalign.
REQ-012 memread and memwrite both 1 SHALL be treated as a load.
REQ-013 mem_ack outside REQ SHALL be ignored.
REQ-014 Minimum operation latency SHALL be 2 cycles from acceptance to done, given mem_ack in the first REQ cycle. There SHALL be no upper bound; the block waits indefinitely for mem_ack.

Reset
REQ-015 While rst = 0, the block SHALL be forced to IDLE, and all of the following SHALL be 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, data_o, done, misalign, stall. ex_ready SHALL be 1.
REQ-016 Reset asserted mid-operation SHALL abandon the access immediately: mem_req drops asynchronously and any later mem_ack is ignored.

Structure
REQ-017 The funct3 encodings, the state encodings and `REG_DATA_WIDTH SHALL reside in the shared riscv_def include.
REQ-018 Load extraction and extension SHALL be a separate combinational sub-module, load_extend (rdata, offset, funct3 -> data).

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- LW, addr 0x100, mem_rdata 0xDEADBEEF, mem_ack after 3 cycles -> mem_be 1111, mem_addr 0x100, data_o 0xDEADBEEF, done after 5 cycles total.
- LB, addr 0x103, rdata 0x80FF0000 -> data_o 0xFFFFFF80; LBU same -> 0x00000080; LHU, addr 0x102 -> 0x000080FF.
- SB, addr 0x201, store_data 0x000000AB -> mem_be 0010, mem_wdata 0xABABABAB, mem_we 1, data_o unchanged.
- LW, addr 0x102 -> misalign pulse, mem_req never asserted, ex_ready 1 on the following cycle.
- rst low during REQ, then mem_ack after reset release -> mem_req 0 immediately, all outputs at reset values, no done.
- Back-to-back SW then LH, each with mem_ack in the first REQ cycle -> two done pulses 3 cycles apart, stall 1 throughout both REQ states.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared RISC-V definitions for the load/store unit: register width, funct3
// load/store encodings, FSM state encoding and the alignment rule.
`ifndef RISCV_DEF_SVH
`define RISCV_DEF_SVH
`define REG_DATA_WIDTH 32
`endif

package load_store_unit_pkg;

  localparam int XLEN = `REG_DATA_WIDTH;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Halves need an even address, words need a word-aligned address.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return ~off[0];
      F3_W:        return (off == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction: shift the bus word down to the addressed byte and
// sign- or zero-extend according to the load width.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from EX/MEM, checks alignment,
// drives a single-beat bus request and returns the extended load result.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] data_o,
  output logic            done,
  output logic            misalign,
  output logic            stall
);

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off,
                                         input logic ld);
    if (ld) return 4'b1111;
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size,
                                                 input logic [XLEN-1:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  lsu_state_e      state, state_nxt;
  logic [XLEN-1:0] addr_p0, store_data_p0, load_data;
  logic [2:0]      funct3_p0;
  logic            load_p0, store_p0;
  logic            mem_op, aligned, accept;

  assign mem_op  = memread | memwrite;
  assign aligned = is_aligned(funct3, addr[1:0]);
  assign accept  = ex_valid & ex_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ex_ready  = 1'b0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid & mem_op & aligned) begin
          state_nxt = ST_REQ;
          stall     = rst;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: operation captured at the accept edge; read-and-write counts as a load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p0       <= '0;
      store_data_p0 <= '0;
      funct3_p0     <= '0;
      load_p0       <= 1'b0;
      store_p0      <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      misalign <= accept & mem_op & ~aligned;
      if (accept) begin
        addr_p0       <= addr;
        store_data_p0 <= store_data;
        funct3_p0     <= funct3;
        load_p0       <= memread;
        store_p0      <= memwrite & ~memread;
      end
    end
  end

  assign mem_we    = mem_req & store_p0;
  assign mem_addr  = mem_req ? {addr_p0[XLEN-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? lane_be(funct3_p0[1:0], addr_p0[1:0], load_p0) : 4'b0000;
  assign mem_wdata = mem_we ? lane_wdata(funct3_p0[1:0], store_data_p0) : '0;

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (addr_p0[1:0]),
    .funct3 (funct3_p0),
    .data   (load_data)
  );

  // p1: load result captured on the acknowledge cycle, held until the next load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     data_o <= '0;
    else if ((state == ST_REQ) & mem_ack & load_p0) data_o <= load_data;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] data_o;
  logic        done, misalign, stall;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int done_cyc = 0;
  int first_done = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .memread(memread), .memwrite(memwrite), .funct3(funct3), .addr(addr),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .data_o(data_o), .done(done),
    .misalign(misalign), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle just after a rising edge; returns at the negedge of the done cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int ack_cyc, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    ex_valid = 1'b1; memread = rd; memwrite = wr; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    check("accept_ready", 32'(ex_ready), 32'd1);
    check("accept_stall", 32'(stall), 32'd1);
    next_cycle();
    ex_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    addr = 32'h5555_5557; store_data = 32'h0; funct3 = 3'b111;
    for (int i = 1; i <= ack_cyc; i++) begin
      mem_ack   = (i == ack_cyc);
      mem_rdata = (i == ack_cyc) ? rdata : 32'h0;
      @(negedge clk);
      check("req", 32'(mem_req), 32'd1);
      check("req_stall", 32'(stall), 32'd1);
      check("req_ready", 32'(ex_ready), 32'd0);
      check("req_addr", mem_addr, {a[31:2], 2'b00});
      check("req_be", 32'(mem_be), 32'(exp_be));
      check("req_we", 32'(mem_we), 32'(wr & ~rd));
      if (wr && !rd) check("req_wdata", mem_wdata, exp_wd);
      check("req_done", 32'(done), 32'd0);
      next_cycle();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("resp_done", 32'(done), 32'd1);
    check("resp_req", 32'(mem_req), 32'd0);
    done_cyc = cyc;
  endtask

  initial begin
    // Reset state, including with a valid op presented during reset
    ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    ex_valid = 1'b0; memread = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // LW 0x100, ack in the third REQ cycle: done in the fifth cycle counting accept
    first_done = cyc;
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0);
    check("lw_latency", 32'(done_cyc - first_done), 32'd4);
    check("lw_data", data_o, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("lw_done_pulse", 32'(done), 32'd0);
    check("lw_ready_after", 32'(ex_ready), 32'd1);
    check("lw_data_hold", data_o, 32'hDEADBEEF);
    next_cycle();

    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 4'b1111, 32'h0);
    check("lb_data", data_o, 32'hFFFFFF80);
    next_cycle();
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 4'b1111, 32'h0);
    check("lbu_data", data_o, 32'h00000080);
    next_cycle();
    do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 1, 4'b1111, 32'h0);
    check("lhu_data", data_o, 32'h000080FF);
    next_cycle();
    // Read and write together behaves as a load
    do_op(1'b1, 1'b1, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 2, 4'b1111, 32'h0);
    check("lh_rw_data", data_o, 32'hFFFF80FF);
    next_cycle();

    do_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1, 4'b0010, 32'hABABABAB);
    check("sb_data_hold", data_o, 32'hFFFF80FF);
    next_cycle();
    do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 4'b1100, 32'hBEEFBEEF);
    check("sh_data_hold", data_o, 32'hFFFF80FF);
    next_cycle();

    // Misaligned LW: pulse next cycle, no bus request
    ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h102;
    @(negedge clk);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_req0", 32'(mem_req), 32'd0);
    next_cycle();
    ex_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_req1", 32'(mem_req), 32'd0);
    check("mis_ready", 32'(ex_ready), 32'd1);
    next_cycle();
    @(negedge clk);
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_req2", 32'(mem_req), 32'd0);
    check("mis_done", 32'(done), 32'd0);

    // Misaligned SH
    next_cycle();
    ex_valid = 1'b1; memwrite = 1'b1; funct3 = 3'b001; addr = 32'h301;
    next_cycle();
    ex_valid = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    check("mis_sh_pulse", 32'(misalign), 32'd1);
    check("mis_sh_req", 32'(mem_req), 32'd0);

    // Valid without a memory op: accepted silently
    next_cycle();
    ex_valid = 1'b1; funct3 = 3'b010; addr = 32'h102;
    @(negedge clk);
    check("nop_ready", 32'(ex_ready), 32'd1);
    check("nop_stall", 32'(stall), 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    @(negedge clk);
    check("nop_req", 32'(mem_req), 32'd0);
    check("nop_misalign", 32'(misalign), 32'd0);
    check("nop_done", 32'(done), 32'd0);
    next_cycle();

    // Back-to-back SW then LH with immediate acks
    do_op(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1, 4'b1111, 32'h12345678);
    first_done = done_cyc;
    next_cycle();
    do_op(1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 32'h80010000, 1, 4'b1111, 32'h0);
    check("b2b_spacing", 32'(done_cyc - first_done), 32'd3);
    check("b2b_lh_data", data_o, 32'hFFFF8001);
    next_cycle();

    // Reset asserted in REQ, then a stale ack after release
    ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h300;
    next_cycle();
    ex_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("rr_req_before", 32'(mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rr_req", 32'(mem_req), 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_ready", 32'(ex_ready), 32'd1);
    check("rr_addr", mem_addr, 32'h0);
    check("rr_be", 32'(mem_be), 32'd0);
    check("rr_data", data_o, 32'h0);
    check("rr_done", 32'(done), 32'd0);
    next_cycle();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rr_ack_req", 32'(mem_req), 32'd0);
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("rr_ack_done", 32'(done), 32'd0);
    check("rr_ack_data", data_o, 32'h0);
    check("rr_ack_ready", 32'(ex_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
